subtractor_serial: RTL and testbench

//  Multi-cycle, digit-serial unsigned subtractor with start/ready/valid handshake;

---
 rtl/subtractor_serial_pkg.sv | 16 +
 rtl/subtractor_serial_if.sv | 22 ++
 rtl/subtractor_serial_sub_digit.sv | 17 +
 rtl/subtractor_serial.sv | 126 ++++++++++++
 tb/tb_subtractor_serial.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/subtractor_serial_pkg.sv
// Shared definitions for the digit-serial arithmetic blocks: FSM encoding and
// the digit-counter width helper.
package subtractor_serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // One extra bit so the counter can hold the full digit count without wrapping.
    function automatic int cnt_width(input int wl, input int digit);
        return $clog2(wl / digit) + 1;
    endfunction

endpackage

// File: rtl/subtractor_serial_if.sv
// Start/ready/valid operand and result bundle for the serial subtractor.
interface subtractor_serial_if #(
    parameter int WL = 4
);
    logic          iEN;
    logic [WL-1:0] idata1;
    logic [WL-1:0] idata2;
    logic          oready;
    logic          ovalid;
    logic [WL:0]   odata;
    logic          oborrow;

    modport master (
        output iEN, idata1, idata2,
        input  oready, ovalid, odata, oborrow
    );

    modport slave (
        input  iEN, idata1, idata2,
        output oready, ovalid, odata, oborrow
    );
endinterface

// File: rtl/subtractor_serial_sub_digit.sv
// Combinational DIGIT-wide subtract with borrow: {bout, diff} = a - b - bin.
module sub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] diff,
    output logic             bout
);
    logic [DIGIT:0] full;

    // The extra top bit goes negative exactly when a borrow leaves this digit.
    assign full = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
    assign diff = full[DIGIT-1:0];
    assign bout = full[DIGIT];
endmodule

// File: rtl/subtractor_serial.sv
// Digit-serial unsigned subtractor: odata = {0,idata1} - {0,idata2} over
// WL/DIGIT busy cycles, LSB digit first, with a registered one-cycle ovalid.
module subtractor_serial
    import subtractor_serial_pkg::*;
#(
    parameter int WL    = 4,
    parameter int DIGIT = 1
) (
    input  logic                iCLK,
    input  logic                iRST,
    subtractor_serial_if.slave  bus
);
    localparam int NDIG = WL / DIGIT;
    localparam int CW   = cnt_width(WL, DIGIT);

    if (DIGIT < 1 || (WL % DIGIT) != 0) begin : g_bad_digit
        $error("subtractor_serial: DIGIT (%0d) must divide WL (%0d)", DIGIT, WL);
    end
    if ($bits(bus.idata1) != WL) begin : g_bad_bus
        $error("subtractor_serial: interface width does not match WL (%0d)", WL);
    end

    state_e          state_q,   state_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [WL-1:0]   a_q,       a_d;
    logic [WL-1:0]   b_q,       b_d;
    logic [WL-1:0]   res_q,     res_d;
    logic            borrow_q,  borrow_d;
    logic [WL:0]     odata_q,   odata_d;
    logic            oborrow_q, oborrow_d;
    logic            ovalid_q,  ovalid_d;

    logic [DIGIT-1:0] dig_diff;
    logic             dig_bout;

    sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .bin  (borrow_q),
        .diff (dig_diff),
        .bout (dig_bout)
    );

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        borrow_d  = borrow_q;
        odata_d   = odata_q;
        oborrow_d = oborrow_q;
        ovalid_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.iEN) begin
                    a_d      = bus.idata1;
                    b_d      = bus.idata2;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end
            end

            S_BUSY: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                // Result digits enter at the top so the first digit ends up at bit 0.
                res_d    = (res_q >> DIGIT) | (WL'(dig_diff) << (WL - DIGIT));
                borrow_d = dig_bout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_d == CW'(NDIG)) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                odata_d   = {borrow_q, res_q};
                oborrow_d = borrow_q;
                ovalid_d  = 1'b1;
                state_d   = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            borrow_q  <= 1'b0;
            odata_q   <= '0;
            oborrow_q <= 1'b0;
            ovalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            borrow_q  <= borrow_d;
            odata_q   <= odata_d;
            oborrow_q <= oborrow_d;
            ovalid_q  <= ovalid_d;
        end
    end

    assign bus.oready  = (state_q == S_IDLE);
    assign bus.ovalid  = ovalid_q;
    assign bus.odata   = odata_q;
    assign bus.oborrow = oborrow_q;

    // The result pulse lands on the cycle the block is back in IDLE.
    a_valid_when_ready: assert property (@(posedge iCLK) disable iff (iRST)
        bus.ovalid |-> bus.oready);
    a_borrow_is_sign: assert property (@(posedge iCLK) disable iff (iRST)
        bus.oborrow == bus.odata[WL]);
endmodule

// File: tb/tb_subtractor_serial.sv
// Scoreboarded random/directed bench for two subtractor_serial configurations
// (WL=4/DIGIT=1 and WL=8/DIGIT=2), driven in lock-step.
module tb_subtractor_serial;
    localparam int LAT = 5;   // accept edge -> ovalid, both configs have 4 digits

    logic iCLK = 1'b0;
    logic iRST;
    always #5 iCLK = ~iCLK;

    subtractor_serial_if #(.WL(4)) if4 ();
    subtractor_serial_if #(.WL(8)) if8 ();

    subtractor_serial #(.WL(4), .DIGIT(1)) u_dut4 (.iCLK(iCLK), .iRST(iRST), .bus(if4.slave));
    subtractor_serial #(.WL(8), .DIGIT(2)) u_dut8 (.iCLK(iCLK), .iRST(iRST), .bus(if8.slave));

    typedef struct {
        logic [8:0] data;
        logic       borrow;
        int         acc;
    } exp_t;

    exp_t       q4[$];
    exp_t       q8[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_acc = -100;
    logic [8:0] held4 = '0;
    logic [8:0] held8 = '0;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Busy window: the accept cycle plus the following LAT-1 cycles.
    function automatic bit model_ready(input int k);
        return !(k >= last_acc && k <= last_acc + LAT - 1);
    endfunction

    function automatic exp_t ref_sub(input int a, input int b, input int wl, input int acc);
        exp_t e;
        e.data   = 9'((a - b) & ((1 << (wl + 1)) - 1));
        e.borrow = (a < b);
        e.acc    = acc;
        return e;
    endfunction

    // Called on a falling edge; drives for the next rising edge and predicts acceptance.
    task automatic step(input bit en, input int a4, input int b4, input int a8, input int b8);
        if4.iEN = en;  if4.idata1 = 4'(a4);  if4.idata2 = 4'(b4);
        if8.iEN = en;  if8.idata1 = 8'(a8);  if8.idata2 = 8'(b8);
        if (en && !iRST && model_ready(cyc)) begin
            q4.push_back(ref_sub(a4, b4, 4, cyc + 1));
            q8.push_back(ref_sub(a8, b8, 8, cyc + 1));
            last_acc = cyc + 1;
        end
        @(negedge iCLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0);
    endtask

    // Monitor: samples just after each falling edge, independent of stimulus.
    initial begin
        exp_t e;
        forever begin
            @(negedge iCLK);
            #1;
            check("oready4", 32'(if4.oready), 32'(model_ready(cyc)));
            check("oready8", 32'(if8.oready), 32'(model_ready(cyc)));
            if (if4.ovalid) begin
                if (q4.size() == 0) check("spurious_ovalid4", 1, 0);
                else begin
                    e = q4.pop_front();
                    check("odata4", 32'(if4.odata), 32'(e.data));
                    check("oborrow4", 32'(if4.oborrow), 32'(e.borrow));
                    check("latency4", 32'(cyc - e.acc), LAT);
                    held4 = e.data;
                end
            end else begin
                check("hold4", 32'(if4.odata), 32'(held4));
            end
            if (if8.ovalid) begin
                if (q8.size() == 0) check("spurious_ovalid8", 1, 0);
                else begin
                    e = q8.pop_front();
                    check("odata8", 32'(if8.odata), 32'(e.data));
                    check("oborrow8", 32'(if8.oborrow), 32'(e.borrow));
                    check("latency8", 32'(cyc - e.acc), LAT);
                    held8 = e.data;
                end
            end else begin
                check("hold8", 32'(if8.odata), 32'(held8));
            end
        end
    end

    int d4a[5] = '{9, 5, 0, 15, 7};
    int d4b[5] = '{5, 9, 15, 0, 7};
    int d8a[5] = '{200, 0, 255, 128, 1};
    int d8b[5] = '{201, 255, 0, 128, 0};

    initial begin
        iRST = 1'b1;
        if4.iEN = 1'b0;  if4.idata1 = '0;  if4.idata2 = '0;
        if8.iEN = 1'b0;  if8.idata1 = '0;  if8.idata2 = '0;
        @(negedge iCLK);
        @(negedge iCLK);
        iRST = 1'b0;

        // Directed boundaries, one isolated op each.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, d4a[i], d4b[i], d8a[i], d8b[i]);
            idle(6);
        end

        // iEN held high with operands changing every cycle: back-to-back ops.
        for (int i = 0; i < 30; i++)
            step(1'b1, $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 255), $urandom_range(0, 255));
        idle(6);

        // Reset two cycles into BUSY discards the op.
        step(1'b1, 3, 12, 17, 99);
        idle(2);
        iRST = 1'b1;
        q4.delete();
        q8.delete();
        last_acc = -100;
        held4 = '0;
        held8 = '0;
        #1;
        check("rst_oready4", 32'(if4.oready), 1);
        check("rst_odata4", 32'(if4.odata), 0);
        check("rst_ovalid8", 32'(if8.ovalid), 0);
        check("rst_odata8", 32'(if8.odata), 0);
        @(negedge iCLK);
        idle(1);
        iRST = 1'b0;
        step(1'b1, 12, 3, 99, 17);
        idle(6);

        // Randomized traffic with random gaps.
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 2) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 255), $urandom_range(0, 255));
        idle(8);

        check("leftover4", 32'(q4.size()), 0);
        check("leftover8", 32'(q8.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
